// File: rtl/cache_pkg.sv
// Shared constants, field widths and FSM state type for the cache fill path.
package cache_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned OFFSET_W        = 4;

    // Address field split: tag | set | byte offset.
    localparam int unsigned TAG_W = 6;
    localparam int unsigned SET_W = 6;
    localparam int unsigned OFF_W = 4;

    // Counters need one extra bit so they can hold WORDS_PER_BLOCK itself.
    localparam int unsigned CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    // Clears the byte offset so the block base is block-aligned.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    // Byte address of word idx within the block at base (2 bytes per word).
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        logic [ADDR_W-1:0] off;
        off            = '0;
        off[CNT_W:1]   = idx;
        return base + off;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Resettable up-counter with enable, synchronous clear and a below-limit compare.
module fill_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             below_limit
);

    // Clear wins over enable so a new fill always starts from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign below_limit = (count < WIDTH'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Block fill engine: on a cache miss, issues one read per word to pipelined
// memory and streams the returned words into the cache data and tag arrays.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_word_addr,
    output logic [DATA_W-1:0] cache_data
);

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic              busy;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic              issue_below;
    logic              ret_below;
    logic              start_fill;
    logic              in_fill;
    logic              accept;
    logic              last_word;

    assign in_fill    = (state == FILL);
    assign start_fill = (state == IDLE) && miss_detected;

    // A return is only legal while a request is outstanding; anything else is spurious.
    assign accept    = in_fill && memory_data_valid && (ret_cnt < issue_cnt);
    assign last_word = (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    fill_counter #(
        .WIDTH (CNT_W),
        .LIMIT (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_fill),
        .en          (memory_read),
        .count       (issue_cnt),
        .below_limit (issue_below)
    );

    fill_counter #(
        .WIDTH (CNT_W),
        .LIMIT (WORDS_PER_BLOCK)
    ) u_ret_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_fill),
        .en          (accept),
        .count       (ret_cnt),
        .below_limit (ret_below)
    );

    // FSM: latch the block base on a miss, return to IDLE once the last word lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base  <= block_base(miss_address);
                        busy  <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL: begin
                    // Misses seen here are dropped; the cache re-raises them afterwards.
                    if (accept && last_word) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue and return paths decoded from the registered state and counters.
    always_comb begin
        fsm_busy         = busy;
        memory_read      = in_fill && issue_below;
        memory_address   = '0;
        write_data_array = accept;
        write_tag_array  = accept && last_word;
        cache_word_addr  = '0;
        cache_data       = memory_data;
        if (memory_read) begin
            memory_address = word_addr(base, issue_cnt);
        end
        // On the last word this address shares tag/set with the block base.
        if (accept) begin
            cache_word_addr = word_addr(base, ret_cnt);
        end
    end

    // ret_below is structurally available but the accept compare uses issue_cnt directly.
    logic unused_ok;
    assign unused_ok = ret_below;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model and
// a scoreboard of expected memory requests and cache writes.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_word_addr;
    logic [15:0] cache_data;

    logic        force_valid;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } wr_t;

    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // 4-stage memory pipeline: a request in cycle N returns in cycle N+4.
    logic        pv[4] = '{default: 1'b0};
    logic [15:0] pa[4] = '{default: 16'h0};

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_addr   (cache_word_addr),
        .cache_data        (cache_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pv[0] <= (memory_read === 1'b1);
        pa[0] <= memory_address;
        for (int k = 1; k < 4; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end

    assign memory_data_valid = force_valid | pv[3];
    assign memory_data       = pv[3] ? (pa[3] ^ 16'hFFFF) : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on every request and every cache write.
    always @(negedge clk) begin
        if (memory_read === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("read_unexpected", {31'h0, memory_read}, 32'h0);
            end else begin
                chk("mem_addr", {16'h0, memory_address}, {16'h0, exp_addr_q.pop_front()});
            end
        end
        if (write_data_array === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                chk("write_unexpected", {31'h0, write_data_array}, 32'h0);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("wr_addr", {16'h0, cache_word_addr}, {16'h0, e.addr});
                chk("wr_data", {16'h0, cache_data}, {16'h0, e.data});
                chk("wr_tag", {31'h0, write_tag_array}, {31'h0, e.tag});
            end
        end else if (write_tag_array === 1'b1) begin
            chk("tag_without_data", {31'h0, write_tag_array}, 32'h0);
        end
    end

    task automatic push_block(input logic [15:0] base, input int n_req, input int n_wr);
        for (int i = 0; i < n_req; i++) exp_addr_q.push_back(base + 16'(2 * i));
        for (int i = 0; i < n_wr; i++) begin
            wr_t e;
            e.addr = base + 16'(2 * i);
            e.data = e.addr ^ 16'hFFFF;
            e.tag  = (i == 7);
            exp_wr_q.push_back(e);
        end
    endtask

    // Runs one complete fill; call at posedge+1 while idle. Returns at the first idle negedge.
    task automatic do_fill(input logic [15:0] addr, input bit spur, input bit inject);
        int n;
        push_block({addr[15:4], 4'h0}, 8, 8);
        miss_detected = 1'b1;
        miss_address  = addr;
        force_valid   = spur;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fsm_busy !== 1'b1) break;
            n++;
            @(posedge clk);
            #1;
            force_valid   = 1'b0;
            miss_detected = inject && (n == 3);
            miss_address  = inject ? 16'h1234 : addr;
        end
        chk("busy_cycles", n, 12);
        chk("rd_q_drained", exp_addr_q.size(), 0);
        chk("wr_q_drained", exp_wr_q.size(), 0);
    endtask

    initial begin
        rst           = 1'b0;
        miss_detected = 1'b1;
        miss_address  = 16'h3A56;
        force_valid   = 1'b1;

        // Reset hold with miss and valid asserted.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_hold", {28'h0, fsm_busy, memory_read, write_data_array, write_tag_array},
                32'h0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b1;
        miss_detected = 1'b0;
        force_valid   = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {28'h0, fsm_busy, memory_read, write_data_array, write_tag_array},
            32'h0);
        @(posedge clk);
        #1;

        // Basic fill with an ignored miss at 0x1234 mid-fill.
        do_fill(16'h3A56, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Spurious valid in IDLE and in the first FILL cycle.
        do_fill(16'h0508, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Reset six cycles into a fill of 0x0100: only words 0 and 1 get written.
        push_block(16'h0100, 6, 2);
        miss_detected = 1'b1;
        miss_address  = 16'h0100;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {28'h0, fsm_busy, memory_read, write_data_array, write_tag_array},
            32'h0);
        chk("abort_addrs", {memory_address, cache_word_addr}, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_rd_q", exp_addr_q.size(), 0);
        chk("abort_wr_q", exp_wr_q.size(), 0);

        // Recovery fill after the abort.
        do_fill(16'h0200, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Top-of-address-space block must not wrap into 0x0000.
        do_fill(16'hFFFE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("final_idle", {28'h0, fsm_busy, memory_read, write_data_array, write_tag_array},
            32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
